data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Memory-side responder for the core's load/store port. It accepts one request at a time over a valid/ready handshake and serves it from an internal word-wide synchronous RAM. Byte and half-word stores are done as read-modify-write. Byte and half-word loads are returned zero- or sign-extended, so the core's s2/s3 truncate logic can be bypassed. Misaligned and out-of-range accesses are reported as errors.

## Interface
- DEPTH_WORDS, 1024: RAM depth in 32-bit words; power of two; AW = clog2(DEPTH_WORDS)
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept; high only in IDLE
- req_write  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_size  input  2  00 byte, 01 half, 10 word; 11 is an error
- req_signed  input  1  loads only: sign-extend sub-word data
- req_wdata  input  32  store data; sub-word data is in the low bits
- rsp_valid  output  1  response present; held until accepted
- rsp_ready  input  1  requester accepts response
- rsp_rdata  output  32  load data; 0 for stores and errors
- rsp_error  output  1  misaligned, out of range, or size 11

## Operation
- Accept: req_valid & req_ready at a rising edge. Capture write, addr, size, signed and wdata into registers. Later changes on the req_* inputs are ignored.
- Error check at accept:
  - size 11
  - half with addr[0]=1
  - word with addr[1:0]≠0
  - addr[31:2] ≥ DEPTH_WORDS
- On error: go to RESP with rsp_error=1 and rsp_rdata=0. RAM is not read or written.
- Word index is addr[AW+1:2]. Lane is addr[1:0], little-endian: byte k = bits 8k+7:8k; half at lane 0 or 2.
- FSM states: IDLE, RD, WR, RMW_RD, RMW_WR, RESP.
  - IDLE → RESP on error.
  - IDLE → RD on a load.
  - IDLE → WR on a word store.
  - IDLE → RMW_RD on a byte or half store.
  - RD → RESP. The RAM is read at entry to RD; the extended lane is registered into rsp_rdata on leaving RD.
  - WR → RESP. The RAM word is written on leaving WR.
  - RMW_RD → RMW_WR. The old word is read.
  - RMW_WR → RESP. The merged word is written: only the addressed byte or half is replaced, other lanes are kept.
  - RESP → IDLE on a rising edge with rsp_ready=1; otherwise stay in RESP with outputs stable.
- Load extension:
  - byte/half with req_signed=1: sign-extend.
  - byte/half with req_signed=0: zero-extend.
  - word: req_signed is ignored.
- RAM contents are not reset.

## Timing
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0. No request is accepted while rst_n=0.
- Accept edge is E0. rsp_valid is high after:
  - E1 for errors
  - E2 for loads and word stores
  - E3 for sub-word stores
- The response handshake edge returns the FSM to IDLE. req_ready rises after that edge; at the earliest, the next request is accepted on the following edge.
- Throughput is one access per 3 cycles for loads and word stores with rsp_ready held high.
- req_ready is low in all states except IDLE. A req_valid held during a busy period is not lost; it is accepted once IDLE is reached.
- A store's RAM write completes before its rsp_valid rises. A load issued after a store's response therefore returns the new data.
- Reset asserted mid-operation:
  - Immediate return to reset values.
  - If reset occurs before the write edge of WR or RMW_WR, the RAM word is unchanged.
  - The pending response is dropped.
- rsp_ready high outside RESP is ignored.

## Test plan
- Word store 0xDEADBEEF to 0x10, then word load of 0x10 → rsp_valid two cycles after each accept, rdata 0xDEADBEEF, rsp_error=0.
- From the state above, byte store 0x55 to 0x12, then word load of 0x10 → 0xDE55BEEF. Store response arrives 3 cycles after accept.
- Loads from 0x10 holding 0xDE55BEEF:
  - byte @0x13, signed → 0xFFFFFFDE
  - byte @0x13, unsigned → 0x000000DE
  - half @0x12, signed → 0xFFFFDE55
  - half @0x10, unsigned → 0x0000BEEF
- Errors: half load @0x11, word store @0x16, size 11, and word load @4×DEPTH_WORDS → each gives rsp_error=1 and rdata=0 one cycle after accept. A later load of 0x14 shows no change.
- Hold rsp_ready=0 for 5 cycles in RESP with a second req_valid pending → rsp_valid and rsp_rdata stay stable and req_ready stays 0. The second request is accepted on the edge after the handshake edge.
- Assert rst_n=0 during RMW_RD of a byte store to 0x10 → outputs return to reset values. A later word load of 0x10 returns the pre-store value.

Source files
------------

// File: rtl/data_mem_responder.sv
// Load/store responder for the core's data port: one request at a time, served from a
// word-wide synchronous RAM with sub-word read-modify-write and extended sub-word loads.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RD     = 3'd1;
  localparam logic [2:0] WR     = 3'd2;
  localparam logic [2:0] RMW_RD = 3'd3;
  localparam logic [2:0] RMW_WR = 3'd4;
  localparam logic [2:0] RESP   = 3'd5;

  logic [2:0]    state;
  logic [AW+1:0] addr_q;
  logic [1:0]    size_q;
  logic          signed_q;
  logic [31:0]   wdata_q;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   ram_q;

  logic          accept;
  logic          req_err;
  logic          ram_rd;
  logic          ram_wr;
  logic [AW-1:0] req_idx;
  logic [AW-1:0] cur_idx;
  logic [7:0]    lane_byte;
  logic [15:0]   lane_half;
  logic [31:0]   load_ext;
  logic [31:0]   merged;
  logic [31:0]   wr_word;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid & req_ready;
  assign req_idx   = req_addr[AW+1:2];
  assign cur_idx   = addr_q[AW+1:2];

  always_comb begin
    req_err = 1'b0;
    case (req_size)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = req_addr[0];
      2'b10:   req_err = |req_addr[1:0];
      default: req_err = 1'b1;
    endcase
    if ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS)) req_err = 1'b1;
  end

  // The RAM is read on the accept edge so the old word is ready for RD and the RMW merge.
  assign ram_rd  = accept & ~req_err & ~(req_write & (req_size == 2'b10));
  assign ram_wr  = (state == WR) || (state == RMW_WR);
  assign wr_word = (state == WR) ? wdata_q : merged;

  always_comb begin
    lane_byte = ram_q[7:0];
    case (addr_q[1:0])
      2'd0: lane_byte = ram_q[7:0];
      2'd1: lane_byte = ram_q[15:8];
      2'd2: lane_byte = ram_q[23:16];
      2'd3: lane_byte = ram_q[31:24];
      default: lane_byte = ram_q[7:0];
    endcase
    lane_half = addr_q[1] ? ram_q[31:16] : ram_q[15:0];

    load_ext = ram_q;
    case (size_q)
      2'b00:   load_ext = {{24{signed_q & lane_byte[7]}}, lane_byte};
      2'b01:   load_ext = {{16{signed_q & lane_half[15]}}, lane_half};
      default: load_ext = ram_q;
    endcase
  end

  always_comb begin
    merged = ram_q;
    if (size_q == 2'b00) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (ram_wr) mem[cur_idx] <= wr_word;
    if (ram_rd) ram_q <= mem[req_idx];
  end

  // Reset only touches the FSM and response registers; a write in flight is simply dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_q    <= '0;
      size_q    <= 2'b00;
      signed_q  <= 1'b0;
      wdata_q   <= '0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q    <= req_addr[AW+1:0];
            size_q    <= req_size;
            signed_q  <= req_signed;
            wdata_q   <= req_wdata;
            rsp_rdata <= '0;
            rsp_error <= req_err;
            if (req_err)                  state <= RESP;
            else if (!req_write)          state <= RD;
            else if (req_size == 2'b10)   state <= WR;
            else                          state <= RMW_RD;
          end
        end
        RD: begin
          rsp_rdata <= load_ext;
          state     <= RESP;
        end
        WR:     state <= RESP;
        RMW_RD: state <= RMW_WR;
        RMW_WR: state <= RESP;
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus randomized
// requests compared against a word-array reference model.
module tb_data_mem_responder;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  int testsRun  = 0;
  int failCount = 0;

  logic [31:0] memModel [DEPTH];

  data_mem_responder #(.DEPTH_WORDS(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_error  (rsp_error)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
    testsRun++;
    if (got !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, expected);
    end
  endtask

  function automatic logic isError(input logic [1:0] s, input logic [31:0] a);
    return (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00) ||
           ((a >> 2) >= 32'(DEPTH));
  endfunction

  function automatic logic [31:0] modelLoad(input logic [1:0] s, input logic sg, input logic [31:0] a);
    logic [31:0] word;
    logic [31:0] v;
    int pos;
    word = memModel[int'(a >> 2)];
    pos  = 8 * int'(a[1:0]);
    if (s == 2'b00) begin
      v = (word >> pos) & 32'hFF;
      if (sg && v >= 32'h80) v = v + 32'hFFFF_FF00;
    end else if (s == 2'b01) begin
      v = (word >> pos) & 32'hFFFF;
      if (sg && v >= 32'h8000) v = v + 32'hFFFF_0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  task automatic modelStore(input logic [1:0] s, input logic [31:0] a, input logic [31:0] wd);
    int idx;
    int pos;
    logic [31:0] mask;
    idx = int'(a >> 2);
    pos = 8 * int'(a[1:0]);
    if (s == 2'b10) begin
      memModel[idx] = wd;
    end else begin
      mask = ((s == 2'b00) ? 32'hFF : 32'hFFFF) << pos;
      memModel[idx] = (memModel[idx] & ~mask) | ((wd << pos) & mask);
    end
  endtask

  task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [1:0] s,
                               input logic sg, input logic [31:0] wd, input int holdCycles);
    logic        err;
    logic [31:0] expData;
    int          expLat;
    int          lat;
    bit          ok;
    err     = isError(s, a);
    expData = (err || w) ? 32'h0 : modelLoad(s, sg, a);
    expLat  = err ? 1 : ((!w || s == 2'b10) ? 2 : 3);

    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = w;
    req_addr   = a;
    req_size   = s;
    req_signed = sg;
    req_wdata  = wd;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    // Scramble request inputs after accept; the DUT must use its captured copy.
    req_valid  = 1'b0;
    req_write  = 1'($urandom);
    req_addr   = $urandom;
    req_size   = 2'($urandom);
    req_signed = 1'($urandom);
    req_wdata  = $urandom;

    lat = 0;
    ok  = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = i;
        ok  = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checkOutput("rsp_timeout", 32'd0, 32'd1);
      return;
    end
    checkOutput("latency", 32'(lat), 32'(expLat));
    checkOutput("rdata", rsp_rdata, expData);
    checkOutput("error", {31'b0, rsp_error}, {31'b0, err});

    for (int i = 0; i < holdCycles; i++) begin
      @(negedge clk);
      checkOutput("hold_valid", {31'b0, rsp_valid}, 32'd1);
      checkOutput("hold_rdata", rsp_rdata, expData);
      checkOutput("hold_ready", {31'b0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    checkOutput("rsp_dropped", {31'b0, rsp_valid}, 32'd0);
    if (w && !err) modelStore(s, a, wd);
  endtask

  // Second request waits on req_valid while the first response is held back.
  task automatic pendingTest();
    logic [31:0] exp1;
    logic [31:0] exp2;
    exp1 = modelLoad(2'b10, 1'b0, 32'h14);
    exp2 = modelLoad(2'b10, 1'b0, 32'h10);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h14; req_size = 2'b10; req_signed = 1'b0;
    checkOutput("pend_ready0", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_addr = 32'h10;
    @(negedge clk);
    @(negedge clk);
    checkOutput("pend_valid1", {31'b0, rsp_valid}, 32'd1);
    checkOutput("pend_rdata1", rsp_rdata, exp1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("pend_hold_valid", {31'b0, rsp_valid}, 32'd1);
      checkOutput("pend_hold_rdata", rsp_rdata, exp1);
      checkOutput("pend_hold_ready", {31'b0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    checkOutput("pend_ready_after", {31'b0, req_ready}, 32'd1);
    checkOutput("pend_idle_valid", {31'b0, rsp_valid}, 32'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("pend_busy", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    checkOutput("pend_valid2", {31'b0, rsp_valid}, 32'd1);
    checkOutput("pend_rdata2", rsp_rdata, exp2);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
    checkOutput({tag, "_valid"}, {31'b0, rsp_valid}, 32'd0);
    checkOutput({tag, "_rdata"}, rsp_rdata, 32'd0);
    checkOutput({tag, "_error"}, {31'b0, rsp_error}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        w;
    logic        sg;
    logic [1:0]  s;
    logic [31:0] a;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = 2'b00;
    req_signed = 1'b0; req_wdata = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 64; i++) applyStimulus(1'b1, 32'(i * 4), 2'b10, 1'b0, $urandom, 0);

    applyStimulus(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 0);
    applyStimulus(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 0);
    applyStimulus(1'b1, 32'h12, 2'b00, 1'b0, 32'h55, 0);
    applyStimulus(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 0);
    applyStimulus(1'b0, 32'h13, 2'b00, 1'b1, 32'h0, 0);
    applyStimulus(1'b0, 32'h13, 2'b00, 1'b0, 32'h0, 0);
    applyStimulus(1'b0, 32'h12, 2'b01, 1'b1, 32'h0, 0);
    applyStimulus(1'b0, 32'h10, 2'b01, 1'b0, 32'h0, 0);

    applyStimulus(1'b0, 32'h11, 2'b01, 1'b0, 32'h0, 1);
    applyStimulus(1'b1, 32'h16, 2'b10, 1'b0, 32'h12345678, 0);
    applyStimulus(1'b0, 32'h14, 2'b11, 1'b0, 32'h0, 0);
    applyStimulus(1'b1, 32'h14, 2'b11, 1'b0, 32'hCAFEF00D, 0);
    applyStimulus(1'b0, 32'(4 * DEPTH), 2'b10, 1'b0, 32'h0, 0);
    applyStimulus(1'b0, 32'h14, 2'b10, 1'b0, 32'h0, 0);

    pendingTest();

    // Reset lands while a byte store sits in its read phase; the store must vanish.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_size = 2'b00; req_wdata = 32'hA7;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkResetValues("midreset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    checkResetValues("postreset");
    applyStimulus(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 0);

    for (int n = 0; n < 200; n++) begin
      w  = 1'($urandom);
      s  = 2'($urandom_range(0, 3));
      sg = 1'($urandom);
      if ($urandom_range(0, 9) == 0) a = $urandom | 32'h0001_0000;
      else a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 2) != 0) begin
        if (s == 2'b01) a[0] = 1'b0;
        if (s == 2'b10) a[1:0] = 2'b00;
      end
      applyStimulus(w, a, s, sg, $urandom, int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
